// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register with the memory-wait FSM and the load-use hazard
// detector of a five-stage RISC-V style pipeline.
//
// Ports
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   EX_*                 : instruction currently in EX (result, PC, PC+imm,
//                          store data, write-back source, rd, register-use
//                          mask, store flag, funct3)
//   ID_rs1/ID_rs2/       : source registers and register-use mask of the
//   ID_ValidReg            instruction currently in decode
//   flush                : redirect, turns the captured EX entry into a bubble
//   dmem_ready           : data memory completes the MEM access this cycle
//   MEM_*                : registered EX/MEM pipeline contents
//   dmem_req             : MEM stage holds a load or store
//   stall_front          : hold PC, IF/ID and ID/EX
//   bubble_ex            : load ID/EX with a bubble (load-use hazard)
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_ALU_result,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_pc_eximm,
    input  logic [31:0] EX_rs2_data,
    input  logic [1:0]  EX_RegSrc,
    input  logic [4:0]  EX_rd,
    input  logic [2:0]  EX_ValidReg,
    input  logic        EX_MemWrite,
    input  logic [2:0]  EX_funct3,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic [2:0]  ID_ValidReg,
    input  logic        flush,
    input  logic        dmem_ready,
    output logic [31:0] MEM_ALU_result,
    output logic [31:0] MEM_pc,
    output logic [31:0] MEM_pc_eximm,
    output logic [31:0] MEM_rs2_data,
    output logic [1:0]  MEM_RegSrc,
    output logic [4:0]  MEM_rd,
    output logic [2:0]  MEM_ValidReg,
    output logic        MEM_MemRead,
    output logic        MEM_MemWrite,
    output logic [2:0]  MEM_funct3,
    output logic        dmem_req,
    output logic        stall_front,
    output logic        bubble_ex
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    localparam logic [1:0] SRC_LOAD = 2'd1;

    logic [0:0] state;
    logic [0:0] state_next;
    logic       mem_stall;
    logic       load_use;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       ex_is_load;

    assign dmem_req  = MEM_MemRead | MEM_MemWrite;
    assign mem_stall = dmem_req & ~dmem_ready;

    // A load writing rd=0 still counts: x0 filtering belongs to the
    // register file, not to the hazard detector.
    assign ex_is_load = (EX_RegSrc == SRC_LOAD);
    assign rs1_hit    = ID_ValidReg[1] & (ID_rs1 == EX_rd);
    assign rs2_hit    = ID_ValidReg[2] & (ID_rs2 == EX_rd);
    assign load_use   = ex_is_load & EX_ValidReg[0] & ~flush & (rs1_hit | rs2_hit);

    // A memory stall dominates: while MEM is waiting the bubble must not be
    // inserted, otherwise the stalled EX instruction would be lost.
    assign stall_front = mem_stall | load_use;
    assign bubble_ex   = load_use & ~mem_stall;

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (mem_stall)  state_next = MEM_WAIT;
            MEM_WAIT: if (dmem_ready) state_next = RUN;
            default:                  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // EX -> MEM boundary. Capture happens on every edge without a memory
    // stall; a held entry is immune to flush, the redirect unit re-asserts
    // flush until the stall clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MEM_ALU_result <= '0;
            MEM_pc         <= '0;
            MEM_pc_eximm   <= '0;
            MEM_rs2_data   <= '0;
            MEM_RegSrc     <= '0;
            MEM_rd         <= '0;
            MEM_ValidReg   <= '0;
            MEM_MemRead    <= 1'b0;
            MEM_MemWrite   <= 1'b0;
            MEM_funct3     <= '0;
        end else if (!mem_stall) begin
            MEM_ALU_result <= EX_ALU_result;
            MEM_pc         <= EX_pc;
            MEM_pc_eximm   <= EX_pc_eximm;
            MEM_rs2_data   <= EX_rs2_data;
            MEM_RegSrc     <= EX_RegSrc;
            MEM_rd         <= EX_rd;
            MEM_funct3     <= EX_funct3;
            if (flush) begin
                MEM_ValidReg <= '0;
                MEM_MemRead  <= 1'b0;
                MEM_MemWrite <= 1'b0;
            end else begin
                MEM_ValidReg <= EX_ValidReg;
                MEM_MemRead  <= ex_is_load;
                MEM_MemWrite <= EX_MemWrite;
            end
        end
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have inputs EX_ALU_result, EX_pc, EX_pc_eximm, EX_rs2_data  in  32 each: EX-stage ALU result, PC, PC+imm, store data.
REQ-003 SHALL have inputs EX_RegSrc  in  2  (0 ALU, 1 load, 2 pc+imm, 3 pc+4); EX_rd  in  5; EX_ValidReg  in  3  (bit0 rd written, bit1 rs1 read, bit2 rs2 read); EX_MemWrite  in  1; EX_funct3  in  3.
REQ-004 SHALL have inputs ID_rs1, ID_rs2  in  5; ID_ValidReg  in  3  (same encoding as EX_ValidReg), describing the instruction in decode.
REQ-005 SHALL have inputs flush  in  1  (branch/jump redirect, kills the EX instruction); dmem_ready  in  1  (data memory accepts/returns this cycle).
REQ-006 SHALL have registered outputs MEM_ALU_result, MEM_pc, MEM_pc_eximm, MEM_rs2_data  out  32; MEM_RegSrc  out  2; MEM_rd  out  5; MEM_ValidReg  out  3; MEM_MemRead, MEM_MemWrite  out  1; MEM_funct3  out  3.
REQ-007 SHALL have outputs dmem_req  out  1  (memory access in MEM); stall_front  out  1  (hold PC, IF/ID, ID/EX); bubble_ex  out  1  (load ID/EX with a bubble).

Function
REQ-008 SHALL have FSM states RUN and MEM_WAIT; reset state RUN.
REQ-009 dmem_req SHALL equal (MEM_MemRead or MEM_MemWrite), combinational from registered outputs.
REQ-010 In RUN, when dmem_req=1 and dmem_ready=0, the FSM SHALL move to MEM_WAIT next edge and all MEM_* registers SHALL hold.
REQ-011 In MEM_WAIT, MEM_* registers SHALL hold while dmem_ready=0; on dmem_ready=1 the FSM SHALL return to RUN and MEM_* SHALL load from EX on that same edge.
REQ-012 mem_stall SHALL equal dmem_req and not dmem_ready (combinational); the EX/MEM register SHALL capture EX inputs on each edge where mem_stall=0.
REQ-013 On capture, MEM_MemRead SHALL be (EX_RegSrc==1) and MEM_ValidReg SHALL be EX_ValidReg; with flush=1 the captured entry SHALL be a bubble: MEM_ValidReg=0, MEM_MemRead=0, MEM_MemWrite=0, data fields don't-care.
REQ-014 load_use SHALL be 1 when EX_RegSrc==1, EX_ValidReg[0]=1, flush=0, and ((ID_ValidReg[1] and ID_rs1==EX_rd) or (ID_ValidReg[2] and ID_rs2==EX_rd)).
REQ-015 A load writing rd=0 SHALL still raise load_use (x0 filtering is the register file's duty).
REQ-016 stall_front SHALL equal mem_stall or load_use; bubble_ex SHALL equal load_use and not mem_stall.
REQ-017 Load-use stall SHALL last exactly one cycle per dependent pair absent mem_stall: the load moves to MEM, the bubble enters EX, load_use deasserts.
REQ-018 flush and mem_stall simultaneous: mem_stall SHALL win; the flush SHALL not alter held MEM_* contents (the redirecting unit re-asserts flush until stall clears).
REQ-019 Outputs SHALL be glitch-tolerant combinational only for dmem_req, stall_front, bubble_ex; all MEM_* SHALL be flop outputs.

Reset
REQ-020 On rst=1, asynchronously: all MEM_* outputs SHALL be 0, FSM SHALL be RUN, hence dmem_req=0 and stall_front=0 (except load_use driven by live EX/ID inputs).
REQ-021 Reset asserted during MEM_WAIT SHALL abandon the access immediately; after release the first edge SHALL capture EX normally.
REQ-022 Deassertion of rst SHALL take effect on the next rising clk; no capture on the deasserting edge within setup.

Verification
REQ-023 EX: ADD rd=5, ALU_result=0x0000_0010, ValidReg=3'b001; ID idle, dmem_ready=1 -> next cycle MEM_rd=5, MEM_ALU_result=0x10, MEM_ValidReg=1, stall_front=0.
REQ-024 EX: load rd=7 (RegSrc=1); ID: ValidReg=3'b011, rs1=7 -> stall_front=1, bubble_ex=1 that cycle; next cycle MEM_MemRead=1, MEM_rd=7, load_use=0.
REQ-025 MEM: store (MemWrite=1), dmem_ready=0 for 3 cycles then 1 -> stall_front=1 for 3 cycles, MEM_* constant, FSM MEM_WAIT; 4th edge loads new EX entry, state RUN.
REQ-026 flush=1 with EX rd=9 ValidReg=1, no stall -> next cycle MEM_ValidReg=0, dmem_req=0.
REQ-027 rst pulse mid-MEM_WAIT with MEM_rd=3 -> MEM_rd=0, MEM_ValidReg=0, dmem_req=0 immediately without clock edge.
REQ-028 load rd=4 in EX, ID reads rs2=4 but ValidReg[2]=0 -> load_use=0, no stall.
